// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit controller: fetches bytes from upstream character memory and serialises them as 8N1.
// Optional macro PARITY_EN inserts an even-parity bit after the data bits (8E1).
module uart_tx_frame_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FETCH_LAT    = 1,
  parameter int unsigned MAX_BYTES    = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       byte_req,
  output logic       msg_done,
  output logic       txd,
  output logic       busy,
  output logic       overrun
);

  localparam int unsigned BAUD_W = 16;
  localparam int unsigned WAIT_W = 3;
  localparam int unsigned BYTE_W = 6;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_LAT);
  localparam logic [BYTE_W-1:0] BYTE_MAX  = BYTE_W'(MAX_BYTES);

  localparam logic [7:0] BYTE_NEWLINE = 8'h0A;
  localparam logic [7:0] BYTE_IDLE    = 8'hFF;

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, START, DATA, PARITY, STOP, DONE
  } state_t;

  state_t            state;
  logic [BAUD_W-1:0] baudCnt;
  logic [WAIT_W-1:0] waitCnt;
  logic [2:0]        bitIdx;
  logic [BYTE_W-1:0] byteCnt;
  logic [7:0]        dataReg;
  logic              bitEnd;

  assign bitEnd = (baudCnt == BAUD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      txd      <= 1'b1;
      byte_req <= 1'b0;
      msg_done <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
      baudCnt  <= '0;
      waitCnt  <= '0;
      bitIdx   <= '0;
      byteCnt  <= '0;
      dataReg  <= '0;
    end else begin
      byte_req <= 1'b0;
      msg_done <= 1'b0;

      // Baud counter runs only while a frame bit is on the line and reloads at each bit boundary.
      if (state inside {START, DATA, PARITY, STOP}) begin
        baudCnt <= bitEnd ? '0 : baudCnt + BAUD_W'(1);
      end else begin
        baudCnt <= '0;
      end

      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (start) begin
            state    <= REQ;
            byte_req <= 1'b1;
            busy     <= 1'b1;
            byteCnt  <= '0;
            overrun  <= 1'b0;
          end
        end
        REQ: begin
          state   <= WAIT;
          waitCnt <= '0;
        end
        WAIT: begin
          if (waitCnt == WAIT_LAST) begin
            dataReg <= data_in;
            if (data_in == BYTE_IDLE) begin
              state    <= DONE;
              msg_done <= 1'b1;
            end else begin
              state   <= START;
              txd     <= 1'b0;
              byteCnt <= byteCnt + BYTE_W'(1);
            end
          end else begin
            waitCnt <= waitCnt + WAIT_W'(1);
          end
        end
        START: begin
          if (bitEnd) begin
            state  <= DATA;
            bitIdx <= '0;
            txd    <= dataReg[0];
          end
        end
        DATA: begin
          if (bitEnd) begin
            if (bitIdx == 3'd7) begin
`ifdef PARITY_EN
              state <= PARITY;
              txd   <= ^dataReg;
`else
              state <= STOP;
              txd   <= 1'b1;
`endif
            end else begin
              bitIdx <= bitIdx + 3'd1;
              txd    <= dataReg[bitIdx + 3'd1];
            end
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          if (bitEnd) begin
            state <= STOP;
            txd   <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bitEnd) begin
            if (dataReg == BYTE_NEWLINE) begin
              state    <= DONE;
              msg_done <= 1'b1;
            end else if (byteCnt == BYTE_MAX) begin
              state    <= DONE;
              msg_done <= 1'b1;
              overrun  <= 1'b1;
            end else begin
              state    <= REQ;
              byte_req <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          txd   <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Scoreboard bench for uart_tx_frame_ctrl: a UART receiver monitor decodes txd and msg_done
// and compares them against expected characters/message ends queued by the stimulus.
`timescale 1ns/1ps
module tb_uart_tx_frame_ctrl;

  localparam int CPB  = 4;
  localparam int FL   = 1;
  localparam int MAXB = 3;
`ifdef PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Start edge to first txd low: REQ + WAIT(FL+1) cycles.
  localparam int FIRST_LOW  = 2 + FL;
  localparam int CHAR_PITCH = CPB * FRAME_BITS + 2 + FL;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in;
  logic       byte_req, msg_done, txd, busy, overrun;

  typedef struct packed {
    logic       isDone;
    logic [7:0] val;
  } exp_t;

  exp_t       expQ[$];
  int         frameCycs[$];
  logic [7:0] mem [0:15];
  int         ptr;
  int         cyc = 0;
  int         nCompared = 0;
  int         nMismatched = 0;

  uart_tx_frame_ctrl #(
    .CLKS_PER_BIT(CPB),
    .FETCH_LAT   (FL),
    .MAX_BYTES   (MAXB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .data_in (data_in),
    .byte_req(byte_req),
    .msg_done(msg_done),
    .txd     (txd),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Upstream character memory: advances on byte_req, rewinds on msg_done.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr     <= 0;
      data_in <= 8'h00;
    end else if (msg_done) begin
      ptr <= 0;
    end else if (byte_req) begin
      data_in <= mem[ptr[3:0]];
      ptr     <= ptr + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic scoreboard(input string name, input exp_t got);
    exp_t want;
    if (expQ.size() == 0) begin
      nCompared++;
      nMismatched++;
      $display("FAIL %s: unexpected output 0x%0h with nothing queued (t=%0t)", name, got, $time);
    end else begin
      want = expQ.pop_front();
      check(name, 32'(got), 32'(want));
    end
  endtask

  task automatic pushChar(input logic [7:0] v);
    exp_t e;
    e.isDone = 1'b0;
    e.val    = v;
    expQ.push_back(e);
  endtask

  task automatic pushDone(input logic ov, input int reqs);
    exp_t e;
    e.isDone = 1'b1;
    e.val    = {ov, 7'(reqs)};
    expQ.push_back(e);
  endtask

  task automatic pulseStart(output int c0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
  endtask

  task automatic waitDone(input string name, input int budget, output int doneCyc);
    bit seen;
    seen = 1'b0;
    doneCyc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (msg_done) begin
        seen    = 1'b1;
        doneCyc = cyc;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  // Monitor: mid-bit UART receiver plus msg_done / byte_req observer.
  initial begin : monitor
    bit         rxActive;
    int         rxOff;
    int         j;
    logic [7:0] rxByte;
    logic       prevReq;
    int         reqCount;
    exp_t       got;
    rxActive = 1'b0;
    rxOff    = 0;
    rxByte   = '0;
    prevReq  = 1'b0;
    reqCount = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        rxActive = 1'b0;
        prevReq  = 1'b0;
        reqCount = 0;
      end else begin
        if (byte_req) begin
          check("byteReqWidth", 32'(prevReq), 32'd0);
          reqCount++;
        end
        prevReq = byte_req;
        if (!rxActive) begin
          if (txd == 1'b0) begin
            rxActive = 1'b1;
            rxOff    = 0;
            rxByte   = '0;
            frameCycs.push_back(cyc);
          end
        end else begin
          rxOff++;
        end
        if (rxActive && (rxOff % CPB) == CPB / 2) begin
          j = rxOff / CPB;
          if (j == 0) begin
            check("startBit", 32'(txd), 32'd0);
          end else if (j <= 8) begin
            rxByte[j-1] = txd;
`ifdef PARITY_EN
          end else if (j == 9) begin
            check("parityBit", 32'(txd), 32'(^rxByte));
`endif
          end else begin
            check("stopBit", 32'(txd), 32'd1);
            got.isDone = 1'b0;
            got.val    = rxByte;
            scoreboard("rxChar", got);
            rxActive = 1'b0;
          end
        end
        if (msg_done) begin
          got.isDone = 1'b1;
          got.val    = {overrun, 7'(reqCount)};
          scoreboard("msgDone", got);
          reqCount = 0;
        end
      end
    end
  end

  initial begin : stim
    int c0, d1, d2;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rstTxd", 32'(txd), 32'd1);
    check("rstBusy", 32'(busy), 32'd0);
    check("rstByteReq", 32'(byte_req), 32'd0);
    check("rstMsgDone", 32'(msg_done), 32'd0);
    check("rstOverrun", 32'(overrun), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Two-character message ending on newline.
    mem[0] = 8'h63;
    mem[1] = 8'h0A;
    frameCycs.delete();
    pushChar(8'h63);
    pushChar(8'h0A);
    pushDone(1'b0, 2);
    pulseStart(c0);
    waitDone("msg1Seen", 300, d1);
    check("msg1Latency", 32'(d1 - c0), 32'(FIRST_LOW + CHAR_PITCH + CPB * FRAME_BITS));
    check("msg1Frames", 32'(frameCycs.size()), 32'd2);
    if (frameCycs.size() == 2) begin
      check("firstTxdLow", 32'(frameCycs[0] - c0), 32'(FIRST_LOW));
      check("charPitch", 32'(frameCycs[1] - frameCycs[0]), 32'(CHAR_PITCH));
    end
    @(negedge clk);
    check("msg1BusyLow", 32'(busy), 32'd0);
    check("msg1DoneWidth", 32'(msg_done), 32'd0);

    // Idle marker as first byte: nothing transmitted.
    mem[0] = 8'hFF;
    frameCycs.delete();
    pushDone(1'b0, 1);
    pulseStart(c0);
    waitDone("idleSeen", 20, d1);
    check("idleLatency", 32'(d1 - c0), 32'(2 + FL));
    check("idleNoFrame", 32'(frameCycs.size()), 32'd0);
    check("idleOverrun", 32'(overrun), 32'd0);
    @(negedge clk);

    // Byte-count limit without terminator.
    for (int i = 0; i < 16; i++) mem[i] = 8'h41;
    for (int i = 0; i < MAXB; i++) pushChar(8'h41);
    pushDone(1'b1, MAXB);
    pulseStart(c0);
    waitDone("limitSeen", 400, d1);
    @(negedge clk);
    check("overrunSet", 32'(overrun), 32'd1);
    check("limitBusyLow", 32'(busy), 32'd0);

    // Next accepted start clears overrun.
    mem[0] = 8'h0A;
    pushChar(8'h0A);
    pushDone(1'b0, 1);
    pulseStart(c0);
    check("overrunCleared", 32'(overrun), 32'd0);
    waitDone("nlOnlySeen", 200, d1);
    @(negedge clk);

    // Reset during data bit 4 abandons the frame.
    mem[0] = 8'h00;
    mem[1] = 8'h0A;
    pulseStart(c0);
    repeat (FIRST_LOW + CPB * 5 + 1) @(negedge clk);
    check("midFrameTxd", 32'(txd), 32'd0);
    #1 reset = 1'b0;
    #1;
    check("asyncRstTxd", 32'(txd), 32'd1);
    check("asyncRstBusy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    mem[0] = 8'h0A;
    pushChar(8'h0A);
    pushDone(1'b0, 1);
    pulseStart(c0);
    waitDone("postRstSeen", 200, d1);
    @(negedge clk);

    // start held high: one message at a time, re-entry one cycle after IDLE.
    pushChar(8'h0A);
    pushDone(1'b0, 1);
    pushChar(8'h0A);
    pushDone(1'b0, 1);
    @(negedge clk);
    start = 1'b1;
    waitDone("heldFirstSeen", 200, d1);
    @(negedge clk);
    check("heldIdleGap", 32'(busy), 32'd0);
    @(negedge clk);
    check("heldReentryReq", 32'(byte_req), 32'd1);
    start = 1'b0;
    waitDone("heldSecondSeen", 200, d2);
    check("heldSpacing", 32'(d2 - d1), 32'(2 + FIRST_LOW + CPB * FRAME_BITS));

`ifdef PARITY_EN
    // Parity: 0x07 has odd weight (parity 1), 0x03 even weight (parity 0).
    mem[0] = 8'h07;
    mem[1] = 8'h03;
    mem[2] = 8'h0A;
    pushChar(8'h07);
    pushChar(8'h03);
    pushChar(8'h0A);
    pushDone(1'b0, 3);
    pulseStart(c0);
    waitDone("parityMsgSeen", 400, d1);
`endif

    repeat (10) @(negedge clk);
    check("scoreboardDrained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
